// File: rtl/aes_key_expander_if.sv
// Command and round-key stream bundle for the AES key expander.
// Signal suffixes are relative to the expander (slave side).
interface aes_key_expander_if;
    logic         start_i;
    logic [1:0]   key_len_i;
    logic [255:0] key_i;
    logic [127:0] rk_o;
    logic [3:0]   rk_idx_o;
    logic         rk_valid_o;
    logic         rk_ready_i;
    logic         busy_o;
    logic         done_o;
    logic         err_o;

    // Controller / cipher datapath side
    modport master (
        output start_i, key_len_i, key_i, rk_ready_i,
        input  rk_o, rk_idx_o, rk_valid_o, busy_o, done_o, err_o
    );

    // Key expander side
    modport slave (
        input  start_i, key_len_i, key_i, rk_ready_i,
        output rk_o, rk_idx_o, rk_valid_o, busy_o, done_o, err_o
    );
endinterface

// File: rtl/aes_key_expander.sv
// Word-serial AES-128/192/256 key schedule engine. Generates one schedule word per
// cycle (SubWord takes 4/NUM_SBOX cycles) and streams each completed 128-bit round
// key over a valid/ready handshake.
module aes_key_expander #(
    parameter int unsigned NUM_SBOX   = 4,
    parameter bit          ENABLE_256 = 1'b1
) (
    input logic               clk_i,
    input logic               rst_n,
    aes_key_expander_if.slave bus
);

    typedef enum logic [2:0] {StIdle, StLoad, StExpand, StSub, StEmit, StDone} state_e;

    localparam int unsigned SubCycles = 4 / NUM_SBOX;
    localparam logic [1:0]  SubLast   = 2'(SubCycles - 1);

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (x^254, which maps 0 to 0) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] s;
        logic [7:0] r;
        s = b;
        r = 8'h01;
        for (int k = 0; k < 7; k++) begin
            s = gf_mul(s, s);
            r = gf_mul(r, s);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]}
               ^ 8'h63;
    endfunction

    state_e        state_q, state_d;
    logic [5:0]    i_q, i_d;
    logic [2:0]    mod_q, mod_d;        // i mod Nk, tracked alongside i
    logic [255:0]  key_q, key_d;        // shifts left one word per LOAD cycle
    logic [1:0]    key_len_q, key_len_d;
    logic [31:0]   hist_q [8];          // hist_q[0] = w[i-1]
    logic [31:0]   hist_d [8];
    logic [31:0]   coll_q [4];
    logic [31:0]   coll_d [4];
    logic [1:0]    fill_q, fill_d;
    logic [7:0]    rcon_q, rcon_d;
    logic [3:0]    rk_idx_q, rk_idx_d;
    logic [31:0]   sub_word_q, sub_word_d;
    logic [1:0]    sub_cnt_q, sub_cnt_d;
    logic          sub_rcon_q, sub_rcon_d;
    logic          err_q, err_d;

    logic [5:0]    nk;
    logic [2:0]    nk_last;
    logic [3:0]    nr;
    logic [31:0]   w_back;              // w[i-Nk]
    logic          push;
    logic [31:0]   push_word;
    logic          start_illegal;

    // SubWord lanes: the top NUM_SBOX bytes are substituted and rotated to the bottom,
    // so after 4/NUM_SBOX cycles every byte is substituted and back in place.
    logic [8*NUM_SBOX-1:0] lane_in;
    logic [8*NUM_SBOX-1:0] lane_out;
    logic [31:0]           sub_next;

    assign lane_in = sub_word_q[31 -: 8*NUM_SBOX];

    for (genvar g = 0; g < NUM_SBOX; g++) begin : g_lane
        assign lane_out[8*g +: 8] = sbox(lane_in[8*g +: 8]);
    end

    if (NUM_SBOX == 4) begin : g_full
        assign sub_next = lane_out;
    end else begin : g_part
        assign sub_next = {sub_word_q[31-8*NUM_SBOX:0], lane_out};
    end

    assign start_illegal = (bus.key_len_i == 2'd3) || ((bus.key_len_i == 2'd2) && !ENABLE_256);

    // Key-length dependent constants and the w[i-Nk] tap
    always_comb begin
        nk      = 6'd8;
        nk_last = 3'd7;
        nr      = 4'd14;
        w_back  = hist_q[7];
        case (key_len_q)
            2'd0: begin
                nk      = 6'd4;
                nk_last = 3'd3;
                nr      = 4'd10;
                w_back  = hist_q[3];
            end
            2'd1: begin
                nk      = 6'd6;
                nk_last = 3'd5;
                nr      = 4'd12;
                w_back  = hist_q[5];
            end
            default: ;
        endcase
    end

    // Sequencer next state; a word push that fills the collector always diverts to EMIT
    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        mod_d      = mod_q;
        key_d      = key_q;
        key_len_d  = key_len_q;
        hist_d     = hist_q;
        coll_d     = coll_q;
        fill_d     = fill_q;
        rcon_d     = rcon_q;
        rk_idx_d   = rk_idx_q;
        sub_word_d = sub_word_q;
        sub_cnt_d  = sub_cnt_q;
        sub_rcon_d = sub_rcon_q;
        err_d      = 1'b0;
        push       = 1'b0;
        push_word  = 32'h0;

        case (state_q)
            StIdle: begin
                if (bus.start_i) begin
                    if (start_illegal) begin
                        err_d = 1'b1;
                    end else begin
                        key_d     = bus.key_i;
                        key_len_d = bus.key_len_i;
                        i_d       = 6'd0;
                        mod_d     = 3'd0;
                        fill_d    = 2'd0;
                        rcon_d    = 8'h01;
                        rk_idx_d  = 4'd0;
                        sub_cnt_d = 2'd0;
                        state_d   = StLoad;
                    end
                end
            end
            StLoad: begin
                push      = 1'b1;
                push_word = key_q[255:224];
                key_d     = {key_q[223:0], 32'h0};
                if (i_q + 6'd1 == nk) state_d = StExpand;
            end
            StExpand: begin
                if (mod_q == 3'd0) begin
                    sub_word_d = {hist_q[0][23:0], hist_q[0][31:24]};
                    sub_rcon_d = 1'b1;
                    sub_cnt_d  = 2'd0;
                    state_d    = StSub;
                end else if ((nk == 6'd8) && (mod_q == 3'd4)) begin
                    sub_word_d = hist_q[0];
                    sub_rcon_d = 1'b0;
                    sub_cnt_d  = 2'd0;
                    state_d    = StSub;
                end else begin
                    push      = 1'b1;
                    push_word = w_back ^ hist_q[0];
                end
            end
            StSub: begin
                sub_word_d = sub_next;
                sub_cnt_d  = sub_cnt_q + 2'd1;
                if (sub_cnt_q == SubLast) begin
                    push      = 1'b1;
                    push_word = w_back ^ sub_next ^ (sub_rcon_q ? {rcon_q, 24'h0} : 32'h0);
                    sub_cnt_d = 2'd0;
                    state_d   = StExpand;
                    if (sub_rcon_q) rcon_d = xtime(rcon_q);
                end
            end
            StEmit: begin
                if (bus.rk_ready_i) begin
                    for (int k = 0; k < 4; k++) coll_d[k] = 32'h0;
                    rk_idx_d = rk_idx_q + 4'd1;
                    if (rk_idx_q == nr) begin
                        state_d = StDone;
                    end else if (i_q < nk) begin
                        state_d = StLoad;
                    end else begin
                        state_d = StExpand;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (push) begin
            for (int k = 7; k > 0; k--) hist_d[k] = hist_q[k-1];
            hist_d[0]      = push_word;
            coll_d[fill_q] = push_word;
            fill_d         = fill_q + 2'd1;
            i_d            = i_q + 6'd1;
            mod_d          = (mod_q == nk_last) ? 3'd0 : mod_q + 3'd1;
            if (fill_q == 2'd3) state_d = StEmit;
        end
    end

    // State registers with asynchronous abort
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            i_q        <= 6'd0;
            mod_q      <= 3'd0;
            key_q      <= '0;
            key_len_q  <= 2'd0;
            for (int k = 0; k < 8; k++) hist_q[k] <= 32'h0;
            for (int k = 0; k < 4; k++) coll_q[k] <= 32'h0;
            fill_q     <= 2'd0;
            rcon_q     <= 8'h01;
            rk_idx_q   <= 4'd0;
            sub_word_q <= 32'h0;
            sub_cnt_q  <= 2'd0;
            sub_rcon_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            mod_q      <= mod_d;
            key_q      <= key_d;
            key_len_q  <= key_len_d;
            hist_q     <= hist_d;
            coll_q     <= coll_d;
            fill_q     <= fill_d;
            rcon_q     <= rcon_d;
            rk_idx_q   <= rk_idx_d;
            sub_word_q <= sub_word_d;
            sub_cnt_q  <= sub_cnt_d;
            sub_rcon_q <= sub_rcon_d;
            err_q      <= err_d;
        end
    end

    assign bus.rk_valid_o = (state_q == StEmit);
    assign bus.rk_o       = bus.rk_valid_o ? {coll_q[0], coll_q[1], coll_q[2], coll_q[3]} : '0;
    assign bus.rk_idx_o   = rk_idx_q;
    assign bus.busy_o     = (state_q != StIdle);
    assign bus.done_o     = (state_q == StDone);
    assign bus.err_o      = err_q;

endmodule

// File: tb/tb_aes_key_expander.sv
// Directed bench for aes_key_expander: three instances (4/1/2 S-box lanes, the last
// with AES-256 disabled) share one stimulus; a negedge monitor logs every handshake.
module tb_aes_key_expander;

    localparam logic [127:0] K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [191:0] K192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] K256 =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    logic [127:0] exp128 [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   key_len = 2'd0;
    logic [255:0] key = '0;
    logic         ready = 1'b1;
    bit           bp_mode = 1'b0;
    int           cyc = 0;
    int           start_cyc = 0;
    int           n_checks = 0;
    int           n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_key_expander_if if_a ();
    aes_key_expander_if if_b ();
    aes_key_expander_if if_c ();

    assign if_a.start_i = start;   assign if_a.key_len_i = key_len;
    assign if_a.key_i   = key;     assign if_a.rk_ready_i = ready;
    assign if_b.start_i = start;   assign if_b.key_len_i = key_len;
    assign if_b.key_i   = key;     assign if_b.rk_ready_i = ready;
    assign if_c.start_i = start;   assign if_c.key_len_i = key_len;
    assign if_c.key_i   = key;     assign if_c.rk_ready_i = ready;

    aes_key_expander #(.NUM_SBOX(4), .ENABLE_256(1'b1)) dut_a (.clk_i(clk), .rst_n(rst_n), .bus(if_a));
    aes_key_expander #(.NUM_SBOX(1), .ENABLE_256(1'b1)) dut_b (.clk_i(clk), .rst_n(rst_n), .bus(if_b));
    aes_key_expander #(.NUM_SBOX(2), .ENABLE_256(1'b0)) dut_c (.clk_i(clk), .rst_n(rst_n), .bus(if_c));

    logic [127:0] obs_rk    [3];
    logic [3:0]   obs_idx   [3];
    logic         obs_valid [3];
    logic         obs_busy  [3];
    logic         obs_done  [3];
    logic         obs_err   [3];

    assign obs_rk[0] = if_a.rk_o;  assign obs_idx[0] = if_a.rk_idx_o;
    assign obs_rk[1] = if_b.rk_o;  assign obs_idx[1] = if_b.rk_idx_o;
    assign obs_rk[2] = if_c.rk_o;  assign obs_idx[2] = if_c.rk_idx_o;
    assign obs_valid[0] = if_a.rk_valid_o; assign obs_busy[0] = if_a.busy_o;
    assign obs_valid[1] = if_b.rk_valid_o; assign obs_busy[1] = if_b.busy_o;
    assign obs_valid[2] = if_c.rk_valid_o; assign obs_busy[2] = if_c.busy_o;
    assign obs_done[0] = if_a.done_o; assign obs_err[0] = if_a.err_o;
    assign obs_done[1] = if_b.done_o; assign obs_err[1] = if_b.err_o;
    assign obs_done[2] = if_c.done_o; assign obs_err[2] = if_c.err_o;

    int           hs_cnt [3]    = '{default: 0};
    int           done_cnt [3]  = '{default: 0};
    int           err_cnt [3]   = '{default: 0};
    int           busy_cnt [3]  = '{default: 0};
    int           valid_cnt [3] = '{default: 0};
    int           hs_cyc [3]    = '{default: 0};
    int           first_vld [3] = '{default: 0};
    int           exp_idx [3]   = '{default: 0};
    bit           stall [3]     = '{default: 1'b0};
    logic [127:0] prev_rk [3];
    logic [3:0]   prev_idx [3];
    logic [127:0] rk_log [3][256];

    int hs_b [3];
    int dn_b [3];
    int er_b [3];
    int bz_b [3];
    int vl_b [3];

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Handshakes complete on the next posedge, so valid&&ready sampled here is a transfer
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (!rst_n || !obs_busy[d]) begin
                exp_idx[d] = 0;
                stall[d]   = 1'b0;
            end
            if (rst_n) begin
                if (obs_busy[d]) busy_cnt[d]++;
                if (obs_done[d]) done_cnt[d]++;
                if (obs_err[d]) err_cnt[d]++;
                if (obs_valid[d]) begin
                    valid_cnt[d]++;
                    if (exp_idx[d] == 0 && !stall[d]) first_vld[d] = cyc;
                    if (stall[d]) begin
                        check_val("rk_stable", obs_rk[d], prev_rk[d]);
                        check_val("idx_stable", 128'(obs_idx[d]), 128'(prev_idx[d]));
                    end
                    if (ready) begin
                        check_val("rk_idx_order", 128'(obs_idx[d]), 128'(exp_idx[d]));
                        exp_idx[d]++;
                        rk_log[d][hs_cnt[d] % 256] = obs_rk[d];
                        hs_cnt[d]++;
                        hs_cyc[d] = cyc + 1;
                        stall[d]  = 1'b0;
                    end else begin
                        stall[d]    = 1'b1;
                        prev_rk[d]  = obs_rk[d];
                        prev_idx[d] = obs_idx[d];
                    end
                end
            end
        end
    end

    task automatic snap();
        for (int d = 0; d < 3; d++) begin
            hs_b[d] = hs_cnt[d];
            dn_b[d] = done_cnt[d];
            er_b[d] = err_cnt[d];
            bz_b[d] = busy_cnt[d];
            vl_b[d] = valid_cnt[d];
        end
    endtask

    task automatic drive_ready();
        ready = bp_mode ? ($urandom_range(0, 9) < 3) : 1'b1;
    endtask

    task automatic do_start(input logic [1:0] len, input logic [255:0] k);
        @(posedge clk); #1;
        start   = 1'b1;
        key_len = len;
        key     = k;
        @(posedge clk); #1;
        start     = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_idle(input int budget);
        int   n;
        logic timed_out;
        n = 0;
        do begin
            @(posedge clk); #1;
            drive_ready();
            n++;
        end while ((if_a.busy_o || if_b.busy_o || if_c.busy_o) && n < budget);
        timed_out = (n >= budget);
        check_val("idle_timeout", 128'(timed_out), 128'(0));
        ready = 1'b1;
    endtask

    task automatic check_seq128(input int d, input string tag);
        for (int r = 0; r < 11; r++)
            check_val($sformatf("%s_d%0d_rk%0d", tag, d, r), rk_log[d][(hs_b[d] + r) % 256],
                      exp128[r]);
        check_val($sformatf("%s_d%0d_hs", tag, d), 128'(hs_cnt[d] - hs_b[d]), 128'(11));
        check_val($sformatf("%s_d%0d_done", tag, d), 128'(done_cnt[d] - dn_b[d]), 128'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1);
    end

    initial begin
        logic found;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_rk", if_a.rk_o, 128'h0);
        check_val("rst_idx", 128'(if_a.rk_idx_o), 128'h0);
        check_val("rst_valid", 128'(if_a.rk_valid_o), 128'h0);
        check_val("rst_busy", 128'(if_a.busy_o | if_b.busy_o | if_c.busy_o), 128'h0);
        check_val("rst_done", 128'(if_a.done_o), 128'h0);
        check_val("rst_err", 128'(if_a.err_o | if_c.err_o), 128'h0);
        rst_n = 1'b1;

        // AES-128, full ready, garbage in unused low key bits
        snap();
        do_start(2'd0, {K128, 128'hffff_ffff_0000_0000_1234_5678_9abc_def0});
        wait_idle(3000);
        check_val("lat_rk0", 128'(first_vld[0] - start_cyc), 128'(4));
        check_val("lat_last_hs", 128'(hs_cyc[0] - start_cyc), 128'(65));
        for (int d = 0; d < 3; d++) check_seq128(d, "a128");

        // AES-128 under random backpressure, with an illegal start mid-run
        bp_mode = 1'b1;
        snap();
        do_start(2'd0, {K128, 128'h0});
        repeat (10) begin
            @(posedge clk); #1;
            drive_ready();
        end
        start   = 1'b1;
        key_len = 2'd3;
        key     = ~key;
        @(posedge clk); #1;
        start   = 1'b0;
        wait_idle(5000);
        bp_mode = 1'b0;
        for (int d = 0; d < 3; d++) begin
            check_seq128(d, "bp128");
            check_val("bp_no_err", 128'(err_cnt[d] - er_b[d]), 128'(0));
        end

        // AES-192
        snap();
        do_start(2'd1, {K192, 64'h0123_4567_89ab_cdef});
        wait_idle(3000);
        for (int d = 0; d < 3; d++) begin
            check_val("a192_rk0", rk_log[d][hs_b[d] % 256], K192[191:64]);
            check_val("a192_rk1", rk_log[d][(hs_b[d] + 1) % 256],
                      128'h62f8ead2522c6b7bfe0c91f72402f5a5);
            check_val("a192_rk12", rk_log[d][(hs_b[d] + 12) % 256],
                      128'he98ba06f448c773c8ecc720401002202);
            check_val("a192_hs", 128'(hs_cnt[d] - hs_b[d]), 128'(13));
            check_val("a192_done", 128'(done_cnt[d] - dn_b[d]), 128'(1));
        end

        // AES-256: accepted by 4- and 1-lane instances, rejected where disabled
        snap();
        do_start(2'd2, K256);
        wait_idle(3000);
        for (int d = 0; d < 2; d++) begin
            check_val("a256_rk0", rk_log[d][hs_b[d] % 256], K256[255:128]);
            check_val("a256_rk1", rk_log[d][(hs_b[d] + 1) % 256], K256[127:0]);
            check_val("a256_rk14", rk_log[d][(hs_b[d] + 14) % 256],
                      128'hfe4890d1e6188d0b046df344706c631e);
            check_val("a256_hs", 128'(hs_cnt[d] - hs_b[d]), 128'(15));
            check_val("a256_done", 128'(done_cnt[d] - dn_b[d]), 128'(1));
        end
        check_val("no256_err", 128'(err_cnt[2] - er_b[2]), 128'(1));
        check_val("no256_busy", 128'(busy_cnt[2] - bz_b[2]), 128'(0));
        check_val("no256_valid", 128'(valid_cnt[2] - vl_b[2]), 128'(0));
        check_val("a256_lat_slow", 128'(first_vld[1] - start_cyc), 128'(4));

        // Illegal key length
        snap();
        do_start(2'd3, K256);
        repeat (4) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check_val("len3_err", 128'(err_cnt[d] - er_b[d]), 128'(1));
            check_val("len3_busy", 128'(busy_cnt[d] - bz_b[d]), 128'(0));
            check_val("len3_valid", 128'(valid_cnt[d] - vl_b[d]), 128'(0));
        end

        // Reset during the rk5 EMIT, then a clean rerun
        snap();
        do_start(2'd0, {K128, 128'h0});
        found = 1'b0;
        for (int n = 0; n < 400 && !found; n++) begin
            @(posedge clk); #1;
            if (if_a.rk_valid_o && if_a.rk_idx_o == 4'd5) begin
                ready = 1'b0;
                found = 1'b1;
            end
        end
        check_val("rk5_reached", 128'(found), 128'(1));
        repeat (3) @(posedge clk);
        #1;
        check_val("rk5_hold_rk", if_a.rk_o, exp128[5]);
        check_val("rk5_hold_idx", 128'(if_a.rk_idx_o), 128'(5));
        #2;
        rst_n = 1'b0;
        #1;
        check_val("abort_valid", 128'(if_a.rk_valid_o), 128'(0));
        check_val("abort_busy", 128'(if_a.busy_o | if_b.busy_o | if_c.busy_o), 128'(0));
        check_val("abort_rk", if_a.rk_o, 128'h0);
        check_val("abort_idx", 128'(if_a.rk_idx_o), 128'(0));
        check_val("abort_done", 128'(if_a.done_o), 128'(0));
        ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int d = 0; d < 3; d++)
            check_val("abort_no_done", 128'(done_cnt[d] - dn_b[d]), 128'(0));
        snap();
        do_start(2'd0, {K128, 128'h0});
        wait_idle(3000);
        for (int d = 0; d < 3; d++) check_seq128(d, "rerun128");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_key_expander.md
Name: aes_key_expander

Overview:
Parametrised, word-serial AES key-schedule engine that generates all round keys for AES-128, AES-192 and AES-256, selected at run time. It replaces the single-round F-function stage with a self-sequencing expander. It streams 128-bit round keys, in order, over a valid/ready interface to the cipher datapath. S-box throughput is set by a parameter, trading area against latency.

Parameters:
- NUM_SBOX, 4, parallel S-box lanes used by SubWord. Legal values: 1, 2 or 4. SubWord takes 4/NUM_SBOX cycles.
- ENABLE_256, 1, when 0, AES-256 (key_len_i=2) is rejected as an error.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start_i  input  1  begin expansion. Sampled in IDLE only.
- key_len_i  input  2  key length: 0=128, 1=192, 2=256, 3=illegal. Captured with start_i.
- key_i  input  256  cipher key, left-aligned. w0=key_i[255:224]. Unused low bits are ignored. Captured with start_i.
- rk_o  output  128  round key {w[4r],w[4r+1],w[4r+2],w[4r+3]}.
- rk_idx_o  output  4  round index r of rk_o.
- rk_valid_o  output  1  rk_o/rk_idx_o valid.
- rk_ready_i  input  1  consumer accepts a key when rk_valid_o&&rk_ready_i.
- busy_o  output  1  high in every state except IDLE.
- done_o  output  1  one-cycle pulse after the final round key handshake.
- err_o  output  1  one-cycle pulse on a rejected start.

Behaviour:
- Reset values: state=IDLE; all outputs 0; word history, collector, counters 0; rcon=0x01. Reset asserted mid-operation aborts immediately and produces no done_o.
- Nk = 4, 6 or 8. Nr = 10, 12 or 14. Total words = 4*(Nr+1) = 44, 52 or 60. Round keys emitted = Nr+1.
- Internal state:
  - 8-word history shift register holding w[i-1]..w[i-8].
  - Word counter i, 6 bits.
  - 4-word round-key collector with 2-bit fill count.
  - 8-bit rcon.
- States: IDLE, LOAD, EXPAND, SUB, EMIT, DONE.
- IDLE:
  - start_i with illegal length (key_len_i=3, or 2 with ENABLE_256=0): err_o=1 for the next cycle, stay in IDLE.
  - start_i with legal length: capture key and length, set i=0, go to LOAD.
- LOAD:
  - One key word w[i] per cycle is pushed into the history and the collector; i++.
  - When i reaches Nk, go to EXPAND.
- EXPAND (one word per cycle):
  - temp = w[i-1].
  - If i mod Nk==0 → go to SUB on temp rotated left by 1 byte; Rcon is applied afterwards.
  - Else if Nk==8 and i mod 8==4 → go to SUB, no rotate, no Rcon.
  - Else w[i] = w[i-Nk]^temp is pushed this cycle; i++.
- SUB:
  - Each cycle, NUM_SBOX bytes pass through the combinational AES S-box; remaining bytes are held.
  - In the last SUB cycle, w[i] = w[i-Nk]^SubWord(temp)^{rcon,24'h0} (rcon only on the i mod Nk==0 case) is pushed; i++; return to EXPAND.
  - After each rcon use: rcon = xtime(rcon), i.e. {rcon[6:0],1'b0}^(rcon[7]?8'h1b:8'h00).
- Collector:
  - When the collector fill reaches 4 (from LOAD, EXPAND or SUB), the next state is EMIT regardless of the phase.
  - The phase is resumed after the handshake.
- EMIT:
  - rk_valid_o=1. rk_o and rk_idx_o are stable until the handshake.
  - Holding rk_ready_i low stalls the engine indefinitely with no state change.
  - On handshake: clear the collector, increment rk_idx.
    - If rk_idx was Nr → DONE.
    - Else return to the pending phase (LOAD if i<Nk, else EXPAND).
  - AES-192: key words w4/w5 join w6/w7 in round key 1, so LOAD is resumed after the rk0 emit.
- DONE: done_o=1 for one cycle, then IDLE. busy_o falls at the same time.
- start_i while busy_o=1 is ignored.
- Latency: with rk_ready_i=1, rk0 is valid in the 5th cycle after the start edge. AES-128 with NUM_SBOX=4 completes in 4+11+40+10 = 65 cycles to the last handshake.

Test Plan:
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, NUM_SBOX=4, ready=1 → rk0=key; rk1=a0fafe1788542cb123a339392a6c7605; rk10=d014f9a8c9ee2589e13f0cc8b6630ca6; done_o once; 11 handshakes.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b → rk1=62f8ead2522c6b7bfe0c91f72402f5a5; rk12=e98ba06f448c773c8ecc720401002202; 13 handshakes.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, NUM_SBOX=1 → rk14=fe4890d1e6188d0b046df344706c631e; same keys produced as with NUM_SBOX=4, with longer latency.
- Backpressure: rk_ready_i random (≈30% duty) → identical key sequence; rk_o stable while valid&&!ready; rk_idx_o strictly 0..Nr.
- Errors: key_len_i=3, and key_len_i=2 with ENABLE_256=0 → err_o single pulse, busy_o stays 0, no rk_valid_o; start_i pulsed mid-run → ignored.
- Reset: deassert rst_n during the rk5 EMIT → all outputs 0 asynchronously; a new start then reproduces rk0..rk10 correctly with rcon restarting at 0x01.
